// File: rtl/mult_share_arbiter_if.sv
// Request/response bundle between NREQ requesters, the shared multiplier arbiter and one consumer.
// The arbiter takes the slave modport; requesters plus consumer form the master side.
interface mult_share_arbiter_if #(
  parameter int N    = 32,
  parameter int NREQ = 2,
  parameter int ID_W = 1
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [N-1:0]      rsp_result;
  logic              rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_ovf
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one sign-magnitude Q(INTBITS).(FRACBITS) multiplier among NREQ requesters.
// Define MULT_OVF_SAT_EN to saturate overflowing products to signed full scale.
module mult_share_arbiter #(
  parameter int N        = 32,
  parameter int INTBITS  = 12,
  parameter int FRACBITS = 20,
  parameter int NREQ     = 2,
  parameter int ID_W     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mult_share_arbiter_if.slave  bus,
  input  logic                 ovf_clr,
  output logic                 ovf_sticky,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0]    op_a_q, op_a_d;
  logic [N-1:0]    op_b_q, op_b_d;
  logic [ID_W-1:0] op_id_q, op_id_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [N-1:0]    rsp_result_q, rsp_result_d;
  logic            rsp_ovf_q, rsp_ovf_d;
  logic            ovf_sticky_q, ovf_sticky_d;

  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  logic [NREQ-1:0] ready_raw;
  logic            rsp_hs;

  logic [2*N-1:0]  prod;
  logic            prod_ovf;
  logic            prod_sign;
  logic [N-2:0]    mag_out;
  logic            unused_frac;

  // Search starts one past the last winner so every waiting requester is reached within NREQ grants.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  assign prod      = {{(N+1){1'b0}}, op_a_q[N-2:0]} * {{(N+1){1'b0}}, op_b_q[N-2:0]};
  assign prod_ovf  = |prod[2*N-1 -: INTBITS+1];
  assign prod_sign = op_a_q[N-1] ^ op_b_q[N-1];
  assign unused_frac = ^prod[FRACBITS-1:0];

`ifdef MULT_OVF_SAT_EN
  assign mag_out = prod_ovf ? {(N-1){1'b1}} : prod[N+FRACBITS-2:FRACBITS];
`else
  assign mag_out = prod[N+FRACBITS-2:FRACBITS];
`endif

  assign rsp_hs = rsp_valid_q & bus.rsp_ready;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_id_d      = op_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    ovf_sticky_d = ovf_clr ? 1'b0 : ovf_sticky_q;
    ready_raw    = '0;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          ready_raw = NREQ'(1) << grant_id;
          op_a_d    = bus.req_a[int'(grant_id)*N +: N];
          op_b_d    = bus.req_b[int'(grant_id)*N +: N];
          op_id_d   = grant_id;
          rr_ptr_d  = grant_id;
          state_d   = MUL;
        end
      end
      MUL: begin
        rsp_result_d = {prod_sign, mag_out};
        rsp_ovf_d    = prod_ovf;
        rsp_id_d     = op_id_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        // A set from this response wins over a coincident clear.
        if (rsp_hs) begin
          rsp_valid_d  = 1'b0;
          ovf_sticky_d = ovf_sticky_d | rsp_ovf_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= ID_W'(NREQ-1);
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_id_q      <= op_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  // The IDLE state is also the reset state, so gate grants while reset is held.
  assign bus.req_ready  = rst_n ? ready_raw : '0;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_ovf    = rsp_ovf_q;
  assign ovf_sticky     = ovf_sticky_q;
  assign busy           = (state_q != IDLE);

endmodule
